// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share
// one downstream memory interface. Round-robin choice on contention, one
// outstanding downstream transaction, and an optional access timeout that
// aborts a stalled transaction and raises a sticky bus error.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        sysclk,
    input  logic        nrst_in,

    // Instruction fetch port (read only)
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_done,
    output logic [31:0] i_rdata,

    // Data port (read / write)
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,

    // Downstream memory interface
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,

    // Sticky error flag, set by any timeout
    output logic        bus_err
);

    // A zero TIMEOUT turns the abort mechanism off entirely.
    localparam bit          TO_EN    = (TIMEOUT != 0);
    // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int          CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LAST_U   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = LAST_U[CNT_W-1:0];

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t             state_q,   state_d;
    owner_t             owner_q,   owner_d;
    logic               prio_d_q,  prio_d_d;   // 1: data wins the next tie
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               m_we_q,    m_we_d;
    logic [31:0]        m_addr_q,  m_addr_d;
    logic [31:0]        m_wdata_q, m_wdata_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               i_done_q,  i_done_d;
    logic               d_done_q,  d_done_d;
    logic               bus_err_q, bus_err_d;

    // Completion of the current access, either by ack or by timeout
    logic               finish;
    logic [31:0]        fin_data;

    // Next-state, grant and completion logic
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d_d  = prio_d_q;
        cnt_d     = cnt_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        bus_err_d = bus_err_q;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        finish    = 1'b0;
        fin_data  = 32'h0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Grants are combinational; suppressed while reset is held
                // so nothing is ever acknowledged to a requester in reset.
                if (nrst_in && d_req && (!i_req || prio_d_q)) begin
                    d_gnt     = 1'b1;
                    owner_d   = OWN_D;
                    prio_d_d  = 1'b0;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    state_d   = ST_ACCESS;
                end else if (nrst_in && i_req) begin
                    i_gnt     = 1'b1;
                    owner_d   = OWN_I;
                    prio_d_d  = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = 32'h0;
                    state_d   = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // An ack on the final allowed cycle still counts as success.
                if (m_ack) begin
                    finish   = 1'b1;
                    fin_data = m_rdata;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    finish    = 1'b1;
                    fin_data  = 32'h0;
                    bus_err_d = 1'b1;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Route the result to whichever port owns the access; the done
        // pulse lands in the following (IDLE) cycle.
        if (finish) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (owner_q == OWN_D) begin
                d_done_d  = 1'b1;
                d_rdata_d = fin_data;
            end else begin
                i_done_d  = 1'b1;
                i_rdata_d = fin_data;
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge sysclk) begin
        if (!nrst_in) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_I;
            prio_d_q  <= 1'b1;
            cnt_q     <= '0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            prio_d_q  <= prio_d_d;
            cnt_q     <= cnt_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign m_req   = (state_q == ST_ACCESS);
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of expected completions.
module tb_mem_arbiter;

    logic        sysclk = 1'b0;
    logic        nrst_in;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic        i_gnt, i_done, d_gnt, d_done, m_req, m_we, bus_err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    always #5 sysclk = ~sysclk;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .sysclk  (sysclk),
        .nrst_in (nrst_in),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_done  (i_done),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_done  (d_done),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .bus_err (bus_err)
    );

    typedef struct {
        logic        is_d;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    logic gq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic chk_data, input logic [31:0] data);
        exp_t e;
        e.is_d     = is_d;
        e.chk_data = chk_data;
        e.data     = data;
        sb_q.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        nrst_in = 1'b0;
        next_cyc();
        next_cyc();
        nrst_in = 1'b1;
    endtask

    // Monitor: grant exclusivity every cycle and scoreboard pops on done
    always @(negedge sysclk) begin
        exp_t e;
        if (mon_en) begin
            chk("one_grant", {31'b0, i_gnt & d_gnt}, 32'd0);
            chk("no_gnt_in_access", {31'b0, m_req & (i_gnt | d_gnt)}, 32'd0);
            if (i_done === 1'b1 || d_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", {30'b0, i_done, d_done}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_port", {30'b0, i_done, d_done}, e.is_d ? 32'd1 : 32'd2);
                    if (e.chk_data)
                        chk("done_rdata", e.is_d ? d_rdata : i_rdata, e.data);
                    $display("done: port=%s rdata=0x%08h", e.is_d ? "d" : "i",
                             e.is_d ? d_rdata : i_rdata);
                end
            end
        end
    end

    initial begin
        int   hi;
        logic seen_low;
        logic exp_d;

        nrst_in = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; m_rdata = 32'h0;

        // Reset values
        do_reset();
        #1;
        chk("rst_i_gnt",   {31'b0, i_gnt},   32'd0);
        chk("rst_d_gnt",   {31'b0, d_gnt},   32'd0);
        chk("rst_i_done",  {31'b0, i_done},  32'd0);
        chk("rst_d_done",  {31'b0, d_done},  32'd0);
        chk("rst_m_req",   {31'b0, m_req},   32'd0);
        chk("rst_m_we",    {31'b0, m_we},    32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        chk("rst_m_addr",  m_addr,  32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        mon_en = 1'b1;

        // Single fetch, ack two cycles after m_req rises
        next_cyc(); i_req = 1'b1; i_addr = 32'h100; #1;
        chk("f_i_gnt", {31'b0, i_gnt}, 32'd1);
        chk("f_d_gnt", {31'b0, d_gnt}, 32'd0);
        push_exp(1'b0, 1'b1, 32'h0000_0013);
        $display("fetch: addr=0x%08h granted", i_addr);
        next_cyc(); i_req = 1'b0; #1;
        chk("f_m_req",  {31'b0, m_req}, 32'd1);
        chk("f_m_addr", m_addr, 32'h100);
        chk("f_m_we",   {31'b0, m_we},  32'd0);
        chk("f_gnt_off", {31'b0, i_gnt}, 32'd0);
        next_cyc(); #1;
        chk("f_m_req_hold", {31'b0, m_req}, 32'd1);
        next_cyc(); m_ack = 1'b1; m_rdata = 32'h0000_0013; #1;
        chk("f_no_early_done", {31'b0, i_done}, 32'd0);
        next_cyc(); m_ack = 1'b0; m_rdata = 32'h0; #1;
        chk("f_i_done",  {31'b0, i_done}, 32'd1);
        chk("f_i_rdata", i_rdata, 32'h0000_0013);
        chk("f_m_req_low", {31'b0, m_req}, 32'd0);
        next_cyc(); #1;
        chk("f_done_pulse", {31'b0, i_done}, 32'd0);
        chk("f_rdata_hold", i_rdata, 32'h0000_0013);

        // Contention from reset: d, i, d, i
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h400; d_addr = 32'h3000;
        do_reset();
        gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_d = gq.pop_front();
            chk("rr_gnt", {30'b0, d_gnt, i_gnt}, exp_d ? 32'd2 : 32'd1);
            $display("rr: access %0d granted %s", k, d_gnt ? "d" : (i_gnt ? "i" : "-"));
            push_exp(exp_d, 1'b1, 32'hA000_0000 + 32'(k));
            next_cyc(); m_ack = 1'b1; m_rdata = 32'hA000_0000 + 32'(k); #1;
            chk("rr_m_addr", m_addr, exp_d ? 32'h3000 : 32'h400);
            next_cyc(); m_ack = 1'b0; m_rdata = 32'h0;
            if (k == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        #1;
        chk("rr_last_done", {30'b0, d_done, i_done}, 32'd1);
        chk("rr_no_extra_gnt", {30'b0, d_gnt, i_gnt}, 32'd0);

        // Data write with immediate ack, then back-to-back read
        next_cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D; #1;
        chk("w_d_gnt", {31'b0, d_gnt}, 32'd1);
        push_exp(1'b1, 1'b0, 32'h0);
        $display("write: addr=0x%08h data=0x%08h granted", d_addr, d_wdata);
        next_cyc();
        d_we = 1'b0; d_addr = 32'h2004; d_wdata = 32'h0;
        m_ack = 1'b1; m_rdata = 32'h1111_2222; #1;
        chk("w_m_req",   {31'b0, m_req}, 32'd1);
        chk("w_m_we",    {31'b0, m_we},  32'd1);
        chk("w_m_addr",  m_addr,  32'h2000);
        chk("w_m_wdata", m_wdata, 32'hCAFE_F00D);
        next_cyc(); m_ack = 1'b0; m_rdata = 32'h0; #1;
        chk("w_d_done", {31'b0, d_done}, 32'd1);
        chk("w_b2b_gnt", {31'b0, d_gnt}, 32'd1);
        push_exp(1'b1, 1'b1, 32'h55AA_33CC);
        next_cyc(); d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h55AA_33CC; #1;
        chk("r_m_addr",  m_addr,  32'h2004);
        chk("r_m_we",    {31'b0, m_we}, 32'd0);
        chk("r_m_wdata", m_wdata, 32'h0);
        next_cyc(); m_ack = 1'b0; m_rdata = 32'h0; #1;
        chk("r_d_done",  {31'b0, d_done}, 32'd1);
        chk("r_d_rdata", d_rdata, 32'h55AA_33CC);

        // Timeout: no ack, TIMEOUT = 8
        next_cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; #1;
        chk("t_d_gnt", {31'b0, d_gnt}, 32'd1);
        chk("t_bus_err_pre", {31'b0, bus_err}, 32'd0);
        push_exp(1'b1, 1'b1, 32'h0);
        hi = 0;
        seen_low = 1'b0;
        for (int c = 0; c < 20 && !seen_low; c++) begin
            next_cyc(); d_req = 1'b0; #1;
            if (m_req === 1'b1) hi++;
            else seen_low = 1'b1;
        end
        $display("timeout: m_req high for %0d cycles", hi);
        chk("t_access_len", 32'(hi), 32'd8);
        chk("t_d_done",  {31'b0, d_done}, 32'd1);
        chk("t_d_rdata", d_rdata, 32'h0);
        chk("t_bus_err", {31'b0, bus_err}, 32'd1);
        next_cyc(); m_ack = 1'b1; m_rdata = 32'h0000_0BAD; #1;
        chk("t_bus_err_sticky", {31'b0, bus_err}, 32'd1);
        next_cyc(); m_ack = 1'b0; m_rdata = 32'h0; #1;
        chk("t_late_ack_none", {30'b0, d_done, i_done}, 32'd0);
        chk("t_late_ack_mreq", {31'b0, m_req}, 32'd0);
        chk("t_bus_err_still", {31'b0, bus_err}, 32'd1);

        // Reset during the second ACCESS cycle, late ack afterwards
        next_cyc(); i_req = 1'b1; i_addr = 32'h500; #1;
        chk("x_i_gnt", {31'b0, i_gnt}, 32'd1);
        next_cyc(); i_req = 1'b0; #1;
        chk("x_m_req", {31'b0, m_req}, 32'd1);
        next_cyc(); nrst_in = 1'b0; #1;
        next_cyc(); nrst_in = 1'b1; m_ack = 1'b1; m_rdata = 32'h0000_DEAD; #1;
        chk("x_m_req_low", {31'b0, m_req},   32'd0);
        chk("x_m_we",      {31'b0, m_we},    32'd0);
        chk("x_m_addr",    m_addr,  32'h0);
        chk("x_m_wdata",   m_wdata, 32'h0);
        chk("x_i_rdata",   i_rdata, 32'h0);
        chk("x_d_rdata",   d_rdata, 32'h0);
        chk("x_bus_err",   {31'b0, bus_err}, 32'd0);
        chk("x_gnts",      {30'b0, d_gnt, i_gnt}, 32'd0);
        next_cyc(); m_ack = 1'b0; m_rdata = 32'h0; #1;
        chk("x_no_done", {30'b0, d_done, i_done}, 32'd0);
        chk("x_m_req_idle", {31'b0, m_req}, 32'd0);
        next_cyc(); i_req = 1'b1; i_addr = 32'h600; #1;
        chk("x2_i_gnt", {31'b0, i_gnt}, 32'd1);
        push_exp(1'b0, 1'b1, 32'h0000_600D);
        next_cyc(); i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h0000_600D; #1;
        chk("x2_m_addr", m_addr, 32'h600);
        next_cyc(); m_ack = 1'b0; m_rdata = 32'h0; #1;
        chk("x2_i_done",  {31'b0, i_done}, 32'd1);
        chk("x2_i_rdata", i_rdata, 32'h0000_600D);

        next_cyc();
        next_cyc(); #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
